mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch-loss cycles before fetch wins.
REQ-004 SHALL have ports as listed: clk in 1, sole clock; all logic on posedge.
REQ-005 rst in 1, reset, synchronous, active-high.
REQ-006 if_req in 1, fetch request; if_addr in ADDR_W, fetch byte address; if_gnt out 1, fetch accepted this cycle.
REQ-007 if_rvalid out 1, fetch response valid; if_rdata out DATA_W, fetch data.
REQ-008 d_req in 1, data request; d_we in 1, 1 = store; d_addr in ADDR_W; d_wdata in DATA_W.
REQ-009 d_gnt out 1; d_rvalid out 1, data response (load or store); d_rdata out DATA_W; d_err out 1, misaligned-access response flag.
REQ-010 mem_ren, mem_wen out 1; mem_raddr, mem_waddr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W (combinational memory read).

Function
REQ-011 SHALL grant at most one requester per cycle; gnt is combinational from req and internal state.
REQ-012 Granted load or fetch: mem_ren=1, mem_raddr=granted address in grant cycle; mem_rdata SHALL be registered, with rvalid and rdata to the granted requester exactly one cycle after gnt.
REQ-013 Granted store: mem_wen=1, mem_waddr=d_addr, mem_wdata=d_wdata in grant cycle; d_rvalid=1 with d_rdata=0 the next cycle.
REQ-014 Back-to-back grants SHALL be allowed; throughput is one access per cycle.
REQ-015 Policy: data beats fetch when both request, unless starve_cnt==STARVE_LIMIT, in which case fetch is granted.
REQ-016 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle if_req=1 and if_gnt=0; it SHALL clear on if_gnt or when if_req=0.
REQ-017 A data request with d_addr[1:0]!=0 SHALL be granted but not forwarded (mem_ren=mem_wen=0); the next cycle gives d_rvalid=1, d_err=1, d_rdata=0.
REQ-018 Fetch with if_addr[1:0]!=0 SHALL be forwarded with low bits ignored; the memory indexes by address [ADDR_W-1:2].
REQ-019 When no grant is issued, mem_ren=mem_wen=0 and mem addresses/wdata=0.
REQ-020 Response register SHALL hold a one-entry tag {NONE,IF,D_LD,D_ST,D_ERR}; rvalid pulses exactly one cycle per grant.
REQ-021 A requester holding req after gnt SHALL be treated as a new request; there is no implicit hold.
REQ-022 rdata outputs SHALL read 0 when the matching rvalid=0.

Reset
REQ-023 rst=1 at a posedge SHALL clear: tag=NONE, starve_cnt=0, all rvalid/d_err=0, rdata=0.
REQ-024 During rst=1, all gnt, mem_ren and mem_wen SHALL be 0; a response pending from the cycle before reset SHALL be dropped.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: fixed priority and starve_cnt SHALL be replaced by round-robin. A last-winner bit gives the other requester priority on conflict; it resets to favour data first.
REQ-026 Macro absent: REQ-015/016 behaviour applies; no round-robin state exists.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the response-tag enum and default ADDR_W/DATA_W constants.
REQ-028 No sub-module; starvation counter/round-robin bit are local. Instantiated in the core ahead of the shared instruction/data memory.

Verification
REQ-029 Fetch only, if_addr=0x0004, mem word 1=0xDEADBEEF -> if_gnt cycle N, if_rvalid=1, if_rdata=0xDEADBEEF at N+1.
REQ-030 Store d_addr=0x0010, d_wdata=0x12345678, then load 0x0010 -> mem_wen at N; d_rvalid store at N+1; load returns 0x12345678.
REQ-031 if_req and d_req both held high 6 cycles, STARVE_LIMIT=4 -> grants D,D,D,D,IF,D; with MEM_ARB_RR_EN -> D,IF,D,IF,D,IF.
REQ-032 Load d_addr=0x0006 -> no mem_ren; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-033 Grant load at N, rst=1 at N+1 -> no d_rvalid at N+1 or N+2; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: response tags and default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        TAG_NONE  = 3'd0,
        TAG_IF    = 3'd1,
        TAG_D_LD  = 3'd2,
        TAG_D_ST  = 3'd3,
        TAG_D_ERR = 3'd4
    } rsp_tag_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory; one access per cycle, response one cycle after grant.
// Fixed data priority with fetch starvation guard by default; MEM_ARB_RR_EN swaps in round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     pick_if;
    logic     pick_d;
    logic     d_mis;
    rsp_tag_e tag_q, tag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_ARB_RR_EN
    // last_if_q=1 means fetch won most recently, so data wins the next conflict.
    logic last_if_q, last_if_d;

    always_comb begin
        pick_if   = if_req && (!d_req || !last_if_q);
        pick_d    = d_req && !pick_if;
        last_if_d = last_if_q;
        if (if_gnt) begin
            last_if_d = 1'b1;
        end else if (d_gnt) begin
            last_if_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_if_q <= 1'b1;
        end else begin
            last_if_q <= last_if_d;
        end
    end
`else
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved;

    assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        pick_if  = if_req && (!d_req || starved);
        pick_d   = d_req && !pick_if;
        starve_d = '0;
        if (if_req && !if_gnt) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Grants are suppressed while reset is held so nothing reaches memory.
    assign if_gnt = pick_if && !rst;
    assign d_gnt  = pick_d && !rst;
    assign d_mis  = (d_addr[1:0] != 2'b00);

    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        tag_d     = TAG_NONE;
        if (if_gnt) begin
            mem_ren   = 1'b1;
            mem_raddr = if_addr;
            tag_d     = TAG_IF;
        end else if (d_gnt) begin
            if (d_mis) begin
                tag_d = TAG_D_ERR;
            end else if (d_we) begin
                mem_wen   = 1'b1;
                mem_waddr = d_addr;
                mem_wdata = d_wdata;
                tag_d     = TAG_D_ST;
            end else begin
                mem_ren   = 1'b1;
                mem_raddr = d_addr;
                tag_d     = TAG_D_LD;
            end
        end
        rdata_d = (tag_d == TAG_IF || tag_d == TAG_D_LD) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= TAG_NONE;
            rdata_q <= '0;
        end else begin
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
        end
    end

    // A response still in the register when reset arrives is masked, not delivered.
    assign if_rvalid = !rst && (tag_q == TAG_IF);
    assign d_rvalid  = !rst && (tag_q == TAG_D_LD || tag_q == TAG_D_ST || tag_q == TAG_D_ERR);
    assign d_err     = !rst && (tag_q == TAG_D_ERR);
    assign if_rdata  = (!rst && tag_q == TAG_IF)   ? rdata_q : '0;
    assign d_rdata   = (!rst && tag_q == TAG_D_LD) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Vector table plus response scoreboard for mem_arbiter, with a small memory model on the mem port.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_raddr;
    logic [15:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared memory seen by the DUT; word 1 is loaded on every reset.
    bit [31:0] mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            mem[1] <= 32'hDEADBEEF;
        end else if (mem_wen) begin
            mem[mem_waddr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_raddr[7:2]];

    bit [31:0] ref_mem [0:63];

    typedef struct packed {
        logic        ifr;
        logic [15:0] ia;
        logic        dr;
        logic        we;
        logic [15:0] da;
        logic [31:0] wd;
        logic        eif;
        logic        ed;
    } vec_t;

    typedef struct packed {
        logic        ifv;
        logic [31:0] ifd;
        logic        dv;
        logic [31:0] dd;
        logic        err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sbq[$];
    int   checks;
    int   failures;
    int   step;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step=%0d %s actual=%h expected=%h", step, nm, act, exp);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step=%0d scoreboard_empty", step);
        end else begin
            e = sbq.pop_front();
            chk("if_rvalid", if_rvalid, e.ifv);
            chk("if_rdata",  if_rdata,  e.ifd);
            chk("d_rvalid",  d_rvalid,  e.dv);
            chk("d_rdata",   d_rdata,   e.dd);
            chk("d_err",     d_err,     e.err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic        mis;
        logic        e_ren, e_wen;
        logic [15:0] e_raddr, e_waddr;
        logic [31:0] e_wdata;
        rsp_t        r;
        @(negedge clk);
        if_req  = v.ifr;
        if_addr = v.ia;
        d_req   = v.dr;
        d_we    = v.we;
        d_addr  = v.da;
        d_wdata = v.wd;
        #1;
        mis     = (v.da[1:0] != 2'b00);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_raddr = '0;
        e_waddr = '0;
        e_wdata = '0;
        r       = '0;
        if (v.eif) begin
            e_ren   = 1'b1;
            e_raddr = v.ia;
            r.ifv   = 1'b1;
            r.ifd   = ref_mem[v.ia[7:2]];
        end else if (v.ed) begin
            r.dv = 1'b1;
            if (mis) begin
                r.err = 1'b1;
            end else if (v.we) begin
                e_wen   = 1'b1;
                e_waddr = v.da;
                e_wdata = v.wd;
                ref_mem[v.da[7:2]] = v.wd;
            end else begin
                e_ren   = 1'b1;
                e_raddr = v.da;
                r.dd    = ref_mem[v.da[7:2]];
            end
        end
        chk("if_gnt",    if_gnt,    v.eif);
        chk("d_gnt",     d_gnt,     v.ed);
        chk("mem_ren",   mem_ren,   e_ren);
        chk("mem_raddr", mem_raddr, e_raddr);
        chk("mem_wen",   mem_wen,   e_wen);
        chk("mem_waddr", mem_waddr, e_waddr);
        chk("mem_wdata", mem_wdata, e_wdata);
        check_rsp();
        sbq.push_back(r);
        step++;
    endtask

    task automatic check_all_quiet(input string nm);
        chk({nm, "_if_gnt"},    if_gnt,    0);
        chk({nm, "_d_gnt"},     d_gnt,     0);
        chk({nm, "_mem_ren"},   mem_ren,   0);
        chk({nm, "_mem_wen"},   mem_wen,   0);
        chk({nm, "_if_rvalid"}, if_rvalid, 0);
        chk({nm, "_d_rvalid"},  d_rvalid,  0);
        chk({nm, "_d_err"},     d_err,     0);
        chk({nm, "_if_rdata"},  if_rdata,  0);
        chk({nm, "_d_rdata"},   d_rdata,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        step     = 0;
        ref_mem[1] = 32'hDEADBEEF;

        // Order: ifr ia dr we da wd | expected if_gnt d_gnt
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 32'h12345678, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 32'h0,        1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 32'h0,        1'b0, 1'b1});
        vecs.push_back('{1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0});
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            vecs.push_back('{1'b1, 16'h0008, 1'b1, 1'b0, 16'h0010, 32'h0, (k % 2) == 1, (k % 2) == 0});
`else
            vecs.push_back('{1'b1, 16'h0008, 1'b1, 1'b0, 16'h0010, 32'h0, k == 4, k != 4});
`endif
        end
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0011, 32'hCAFEF00D, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h0,        1'b0, 1'b0});

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if_req = 1'b1; d_req = 1'b1; if_addr = 16'h0004; d_addr = 16'h0010;
        #1;
        check_all_quiet("reset");
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        sbq.push_back('0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Load granted, then reset lands before its response is seen.
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        #1;
        chk("rst_seq_d_gnt", d_gnt, 1);
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        #1;
        check_all_quiet("rst_n1");
        @(negedge clk);
        #1;
        check_all_quiet("rst_n2");
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        #1;
        check_all_quiet("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
